// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: default widths and FSM state codes.
package pipeline_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned REG_W_DEF = 5;

  // Execution FSM state codes, visible on the state port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Load-use hazard detection and pipeline-control gating (purely combinational).
// Ports:
//   enable                      global latch enable from the sequencer
//   ID_EX_mem_read, ID_EX_rt    load in EX and its destination register
//   IF_ID_rs, IF_ID_rt          source registers of the instruction in ID
//   branch_taken, jump_sel      control-flow change resolved in ID
//   PC_write, IF_ID_write       PC / IF-ID load permissions
//   IF_ID_flush, ID_EX_bubble   IF-ID clear and ID-EX NOP insertion
module hazard_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic             enable,
  input  logic             ID_EX_mem_read,
  input  logic [REG_W-1:0] ID_EX_rt,
  input  logic [REG_W-1:0] IF_ID_rs,
  input  logic [REG_W-1:0] IF_ID_rt,
  input  logic             branch_taken,
  input  logic             jump_sel,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble
);

  logic stall;

  // Register 0 is hardwired to zero, so a load to it never creates a dependency.
  assign stall = ID_EX_mem_read && (ID_EX_rt != '0) &&
                 ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));

  assign PC_write     = enable & ~stall;
  assign IF_ID_write  = ~stall;
  assign ID_EX_bubble = enable & stall;
  // Stall wins over flush: a branch that depends on the load retries next cycle.
  assign IF_ID_flush  = enable & (branch_taken | jump_sel) & ~stall;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage pipeline: run/step/pause/done FSM, global
// latch enable, hazard gating and an enabled-cycle counter for the debug unit.
// Ports:
//   clock, reset_n                      clock and synchronous active-low reset
//   dbg_run, dbg_step, dbg_pause        debug command pulses
//   halt_wb                             HALT has reached WB
//   ID_EX_*, IF_ID_rs/rt                hazard operands
//   branch_taken, jump_sel              control-flow change in ID
//   enable                              registered global enable
//   PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble   pipeline controls
//   state                               FSM state code
//   cycle_count                         saturating count of enabled cycles
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             dbg_run,
  input  logic             dbg_step,
  input  logic             dbg_pause,
  input  logic             halt_wb,
  input  logic             ID_EX_mem_read,
  input  logic [REG_W-1:0] ID_EX_rt,
  input  logic [REG_W-1:0] IF_ID_rs,
  input  logic [REG_W-1:0] IF_ID_rt,
  input  logic             branch_taken,
  input  logic             jump_sel,
  output logic             enable,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_count
);

  state_e           state_q, state_d;
  logic             enable_q, enable_d;
  logic [CNT_W-1:0] cnt_q;

  // State, enable and counter registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      enable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      if (enable_q && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next state and next enable. While in PAUSE, enable_q high marks the single
  // step cycle (this is also the pending-step flag after a step from IDLE).
  always_comb begin
    state_d  = state_q;
    enable_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dbg_pause) begin
          state_d = ST_IDLE;
        end else if (dbg_step) begin
          state_d  = ST_PAUSE;
          enable_d = 1'b1;
        end else if (dbg_run) begin
          state_d  = ST_RUN;
          enable_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_wb) begin
          state_d = ST_DONE;
        end else if (dbg_pause) begin
          state_d = ST_PAUSE;
        end else begin
          enable_d = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (enable_q && halt_wb) begin
          state_d = ST_DONE;
        end else if (dbg_pause) begin
          state_d = ST_PAUSE;
        end else if (dbg_step) begin
          enable_d = 1'b1;
        end else if (dbg_run) begin
          state_d  = ST_RUN;
          enable_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign enable      = enable_q;
  assign state       = state_q;
  assign cycle_count = cnt_q;

  hazard_unit #(
    .REG_W(REG_W)
  ) u_hazard (
    .enable         (enable_q),
    .ID_EX_mem_read (ID_EX_mem_read),
    .ID_EX_rt       (ID_EX_rt),
    .IF_ID_rs       (IF_ID_rs),
    .IF_ID_rt       (IF_ID_rt),
    .branch_taken   (branch_taken),
    .jump_sel       (jump_sel),
    .PC_write       (PC_write),
    .IF_ID_write    (IF_ID_write),
    .IF_ID_flush    (IF_ID_flush),
    .ID_EX_bubble   (ID_EX_bubble)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (counter narrowed to 8 bits
// so saturation is reachable).
module tb_pipeline_ctrl;

  localparam int unsigned CW = 8;
  localparam int unsigned RW = 5;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          dbg_run, dbg_step, dbg_pause, halt_wb;
  logic          ID_EX_mem_read;
  logic [RW-1:0] ID_EX_rt, IF_ID_rs, IF_ID_rt;
  logic          branch_taken, jump_sel;
  logic          enable, PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble;
  logic [1:0]    state;
  logic [CW-1:0] cycle_count;

  int total = 0;
  int bad   = 0;

  pipeline_ctrl #(.CNT_W(CW), .REG_W(RW)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .dbg_run        (dbg_run),
    .dbg_step       (dbg_step),
    .dbg_pause      (dbg_pause),
    .halt_wb        (halt_wb),
    .ID_EX_mem_read (ID_EX_mem_read),
    .ID_EX_rt       (ID_EX_rt),
    .IF_ID_rs       (IF_ID_rs),
    .IF_ID_rt       (IF_ID_rt),
    .branch_taken   (branch_taken),
    .jump_sel       (jump_sel),
    .enable         (enable),
    .PC_write       (PC_write),
    .IF_ID_write    (IF_ID_write),
    .IF_ID_flush    (IF_ID_flush),
    .ID_EX_bubble   (ID_EX_bubble),
    .state          (state),
    .cycle_count    (cycle_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_haz();
    ID_EX_mem_read = 1'b0; ID_EX_rt = '0; IF_ID_rs = '0; IF_ID_rt = '0;
    branch_taken = 1'b0; jump_sel = 1'b0;
  endtask

  task automatic pulse_run();
    dbg_run = 1'b1; tick(); dbg_run = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (cycle_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cycle_count); end
    total++;
    if ({enable, PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble} !== 5'b00100) begin
      bad++;
      $display("FAIL reset_outs got=%b exp=00100", {enable, PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_run_pause();
    int hi = 0;
    pulse_run();
    for (int i = 0; i < 10; i++) begin
      if (enable === 1'b1) hi++;
      if (i == 9) dbg_pause = 1'b1;
      tick();
      dbg_pause = 1'b0;
    end
    if (enable === 1'b1) hi++;
    total++; if (hi != 10) begin bad++; $display("FAIL run_enable_cycles got=%0d exp=10", hi); end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL run_pause_state got=%0d exp=2", state); end
    total++; if (cycle_count !== 8'd10) begin bad++; $display("FAIL run_count got=%0d exp=10", cycle_count); end
  endtask

  task automatic test_step();
    int hi = 0;
    int st_err = 0;
    for (int k = 0; k < 3; k++) begin
      dbg_step = 1'b1; tick(); dbg_step = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (enable === 1'b1) hi++;
        if (state !== 2'd2) st_err++;
        tick();
      end
    end
    total++; if (hi != 3) begin bad++; $display("FAIL step_pulses got=%0d exp=3", hi); end
    total++; if (st_err != 0) begin bad++; $display("FAIL step_state non_pause_samples=%0d exp=0", st_err); end
    total++; if (cycle_count !== 8'd13) begin bad++; $display("FAIL step_count got=%0d exp=13", cycle_count); end
  endtask

  task automatic test_hazard();
    pulse_run();
    total++; if (state !== 2'd1 || enable !== 1'b1) begin bad++; $display("FAIL haz_run state=%0d en=%b exp=1/1", state, enable); end
    ID_EX_mem_read = 1'b1; ID_EX_rt = 5'd5; IF_ID_rs = 5'd5; #1;
    total++;
    if ({PC_write, IF_ID_write, ID_EX_bubble} !== 3'b001) begin
      bad++; $display("FAIL haz_rs_stall got=%b exp=001", {PC_write, IF_ID_write, ID_EX_bubble});
    end
    ID_EX_rt = 5'd0; IF_ID_rs = 5'd0; #1;
    total++;
    if ({PC_write, IF_ID_write, ID_EX_bubble} !== 3'b110) begin
      bad++; $display("FAIL haz_r0_nostall got=%b exp=110", {PC_write, IF_ID_write, ID_EX_bubble});
    end
    ID_EX_rt = 5'd7; IF_ID_rs = 5'd3; IF_ID_rt = 5'd7; #1;
    total++;
    if ({PC_write, IF_ID_write, ID_EX_bubble} !== 3'b001) begin
      bad++; $display("FAIL haz_rt_stall got=%b exp=001", {PC_write, IF_ID_write, ID_EX_bubble});
    end
    clear_haz(); branch_taken = 1'b1; #1;
    total++; if (IF_ID_flush !== 1'b1) begin bad++; $display("FAIL haz_branch_flush got=%b exp=1", IF_ID_flush); end
    branch_taken = 1'b0; jump_sel = 1'b1; #1;
    total++; if (IF_ID_flush !== 1'b1) begin bad++; $display("FAIL haz_jump_flush got=%b exp=1", IF_ID_flush); end
    jump_sel = 1'b0; branch_taken = 1'b1;
    ID_EX_mem_read = 1'b1; ID_EX_rt = 5'd5; IF_ID_rs = 5'd5; #1;
    total++;
    if ({IF_ID_flush, ID_EX_bubble} !== 2'b01) begin
      bad++; $display("FAIL haz_stall_over_flush got=%b exp=01", {IF_ID_flush, ID_EX_bubble});
    end
    clear_haz(); #1;
  endtask

  task automatic test_halt();
    halt_wb = 1'b1; dbg_pause = 1'b1; tick(); halt_wb = 1'b0; dbg_pause = 1'b0;
    total++; if (state !== 2'd3) begin bad++; $display("FAIL halt_state got=%0d exp=3", state); end
    total++; if (enable !== 1'b0) begin bad++; $display("FAIL halt_enable got=%b exp=0", enable); end
    total++; if (cycle_count !== 8'd14) begin bad++; $display("FAIL halt_count got=%0d exp=14", cycle_count); end
    pulse_run(); tick();
    dbg_step = 1'b1; tick(); dbg_step = 1'b0; tick();
    total++;
    if (state !== 2'd3 || enable !== 1'b0 || cycle_count !== 8'd14) begin
      bad++; $display("FAIL done_absorb state=%0d en=%b cnt=%0d exp=3/0/14", state, enable, cycle_count);
    end
    branch_taken = 1'b1; ID_EX_mem_read = 1'b1; ID_EX_rt = 5'd4; IF_ID_rt = 5'd4; #1;
    total++;
    if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble} !== 4'b0000) begin
      bad++; $display("FAIL done_no_flush_bubble got=%b exp=0000", {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble});
    end
    branch_taken = 1'b0; ID_EX_mem_read = 1'b0; #1;
    total++; if (IF_ID_write !== 1'b1 || PC_write !== 1'b0) begin bad++; $display("FAIL done_gating got=%b%b exp=01", PC_write, IF_ID_write); end
    clear_haz();
  endtask

  task automatic test_reset_mid_run();
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    pulse_run();
    for (int i = 0; i < 37; i++) tick();
    total++; if (cycle_count !== 8'd37 || state !== 2'd1) begin bad++; $display("FAIL pre_reset cnt=%0d state=%0d exp=37/1", cycle_count, state); end
    reset_n = 1'b0; tick();
    total++;
    if (state !== 2'd0 || cycle_count !== 8'd0 || enable !== 1'b0) begin
      bad++; $display("FAIL mid_run_reset state=%0d cnt=%0d en=%b exp=0/0/0", state, cycle_count, enable);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_step_from_idle();
    tick();
    dbg_step = 1'b1; tick(); dbg_step = 1'b0;
    total++; if (state !== 2'd2 || enable !== 1'b1) begin bad++; $display("FAIL idle_step state=%0d en=%b exp=2/1", state, enable); end
    tick();
    total++; if (enable !== 1'b0 || cycle_count !== 8'd1) begin bad++; $display("FAIL idle_step_end en=%b cnt=%0d exp=0/1", enable, cycle_count); end
    dbg_step = 1'b1; tick(); dbg_step = 1'b0;
    halt_wb = 1'b1; tick(); halt_wb = 1'b0;
    total++;
    if (state !== 2'd3 || enable !== 1'b0 || cycle_count !== 8'd2) begin
      bad++; $display("FAIL step_halt state=%0d en=%b cnt=%0d exp=3/0/2", state, enable, cycle_count);
    end
  endtask

  task automatic test_saturate();
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    pulse_run();
    for (int i = 0; i < 254; i++) tick();
    total++; if (cycle_count !== 8'd254) begin bad++; $display("FAIL sat_pre got=%0d exp=254", cycle_count); end
    tick();
    total++; if (cycle_count !== 8'd255) begin bad++; $display("FAIL sat_reach got=%0d exp=255", cycle_count); end
    for (int i = 0; i < 20; i++) tick();
    total++;
    if (cycle_count !== 8'd255 || enable !== 1'b1) begin
      bad++; $display("FAIL sat_hold cnt=%0d en=%b exp=255/1", cycle_count, enable);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    dbg_run = 1'b0; dbg_step = 1'b0; dbg_pause = 1'b0; halt_wb = 1'b0;
    clear_haz();
    test_reset();
    test_run_pause();
    test_step();
    test_hazard();
    test_halt();
    test_reset_mid_run();
    test_step_from_idle();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencer for the 5-stage MIPS/DLX pipeline.
- Owns the global latch `enable` and runs the run/step/pause/done execution FSM driven by debug-unit commands.
- Detects load-use hazards and generates `PC_write`, `IF_ID_write`, the ID/EX bubble and the IF/ID flush.
- Counts executed clock cycles for the debug unit to read.

Parameters:
- CNT_W, 32, width of cycle counter `cycle_count`.
- REG_W, 5, register-specifier width.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  synchronous reset, active-low
- dbg_run  in  1  debug command: free-run (1-cycle pulse)
- dbg_step  in  1  debug command: advance exactly one cycle (1-cycle pulse)
- dbg_pause  in  1  debug command: stop after current cycle (1-cycle pulse)
- halt_wb  in  1  HALT instruction has reached WB stage
- ID_EX_mem_read  in  1  instruction in EX is a load
- ID_EX_rt  in  REG_W  load destination register
- IF_ID_rs  in  REG_W  rs of instruction in ID
- IF_ID_rt  in  REG_W  rt of instruction in ID
- branch_taken  in  1  branch resolved taken in ID
- jump_sel  in  1  jump decoded in ID
- enable  out  1  global pipeline-latch/PC enable
- PC_write  out  1  PC update allowed
- IF_ID_write  out  1  IF/ID load allowed (0 = hold)
- IF_ID_flush  out  1  zero IF/ID contents
- ID_EX_bubble  out  1  load NOP into ID/EX
- state  out  2  FSM state encoding
- cycle_count  out  CNT_W  enabled cycles since reset

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, cycle_count=0.
- While in reset: enable=0, PC_write=0, IF_ID_flush=0, ID_EX_bubble=0, IF_ID_write=1.
- States: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Command priority in the same cycle: dbg_pause > dbg_step > dbg_run.
- IDLE:
  - dbg_run -> RUN.
  - dbg_step -> STEP_PENDING: one-cycle internal flag; state=PAUSE next cycle.
  - otherwise stay.
- RUN:
  - dbg_pause -> PAUSE.
  - halt_wb -> DONE; halt_wb beats dbg_pause.
- PAUSE:
  - dbg_run -> RUN.
  - dbg_step -> exactly one enabled cycle on the following clock, then PAUSE.
  - A halt_wb during that enabled cycle -> DONE.
- DONE: absorbing; only reset_n leaves it. Commands are ignored.
- enable is registered, driven from next-state logic:
  - enable=1 during every cycle the FSM is in RUN.
  - enable=1 for the single step cycle.
  - enable=0 otherwise.
- In the cycle halt_wb is seen, enable drops the next cycle; the HALT cycle itself is enabled.
- Hazard logic (combinational, same cycle):
  - stall = ID_EX_mem_read & (ID_EX_rt != 0) & ((ID_EX_rt == IF_ID_rs) | (ID_EX_rt == IF_ID_rt)).
  - PC_write = enable & ~stall.
  - IF_ID_write = ~stall.
  - ID_EX_bubble = enable & stall.
  - IF_ID_flush = enable & (branch_taken | jump_sel) & ~stall. Stall has priority over flush, so a branch depending on a load waits one cycle.
- With enable=0, no flush or bubble is asserted regardless of the hazard inputs.
- cycle_count:
  - +1 on each posedge where enable=1.
  - Saturates at all-ones; no wrap.
  - Holds in PAUSE, IDLE and DONE.
- Reset mid-RUN or mid-step: immediate return to IDLE with the reset values above, on that edge.

Decomposition:
- Add to definiciones.vh:
  - state codes ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE.
  - REG_W default.
- One sub-module, hazard_unit: pure combinational stall detection plus the PC_write/IF_ID_write/bubble/flush gating.
- pipeline_ctrl keeps the FSM, enable register and counter.

Test Plan:
- Reset, then dbg_run, 10 clocks, dbg_pause -> enable high exactly 10 cycles, state=PAUSE, cycle_count=10.
- From PAUSE, three dbg_step pulses spaced 4 clocks apart -> exactly three single-cycle enable pulses, cycle_count +3, state stays PAUSE.
- RUN with ID_EX_mem_read=1, ID_EX_rt=5, IF_ID_rs=5 -> PC_write=0, IF_ID_write=0, ID_EX_bubble=1 same cycle.
  - Repeat with ID_EX_rt=0 -> no stall.
- RUN, branch_taken=1, no stall -> IF_ID_flush=1.
  - Same with the load hazard active -> IF_ID_flush=0, ID_EX_bubble=1.
- RUN, halt_wb=1 with dbg_pause=1 in the same cycle -> state=DONE, enable=0 next cycle.
  - Subsequent dbg_run ignored; cycle_count frozen.
- reset_n=0 during RUN with cycle_count=37 -> next edge state=IDLE, cycle_count=0, enable=0.
  - Preload the counter to all-ones in RUN -> it stays all-ones.
